// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, pixel type, sink state encoding and the
// raster address helper used by framebuffer_sink.
package fb_pkg;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int FB_ADDR_W = 15;

  typedef logic [2:0] colour_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } fb_state_t;

  // Raster address y*width + x. Both operands are widened to the full
  // address width before the multiply so nothing is truncated ahead of the add.
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [7:0]  x,
                                                   input logic [6:0]  y,
                                                   input int unsigned width = FB_WIDTH);
    logic [FB_ADDR_W-1:0] x_ext;
    logic [FB_ADDR_W-1:0] y_ext;
    x_ext = {{(FB_ADDR_W-8){1'b0}}, x};
    y_ext = {{(FB_ADDR_W-7){1'b0}}, y};
    return (y_ext * FB_ADDR_W'(width)) + x_ext;
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port pixel store: one write port and one registered,
// read-first read port. Written as a plain array so it maps onto block RAM.
module fb_ram #(
  parameter int DATA_W = 3,
  parameter int DEPTH  = 19200,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and registered read share an edge; the read sees the pre-write value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/framebuffer_sink.sv
// Receiving end of the drawers' pixel-plot interface. Captures valid plots
// into the framebuffer, runs the hardware clear-to-colour sequence, counts
// accepted/dropped plots and serves a synchronous read port for scanout.
module framebuffer_sink
  import fb_pkg::*;
#(
  parameter int WIDTH    = FB_WIDTH,
  parameter int HEIGHT   = FB_HEIGHT,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          vga_x,
  input  logic [6:0]          vga_y,
  input  logic [COLOUR_W-1:0] vga_colour,
  input  logic                vga_plot,
  input  logic                clear_start,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                clear_done,
  output logic                busy,
  input  logic [7:0]          rd_x,
  input  logic [6:0]          rd_y,
  output logic [COLOUR_W-1:0] rd_colour,
  output logic [15:0]         plot_count,
  output logic [15:0]         drop_count
);

  localparam int                PIXELS   = WIDTH * HEIGHT;
  localparam int                ADDR_W   = FB_ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(PIXELS - 1);
  localparam logic [7:0]        X_LIMIT  = 8'(WIDTH);
  localparam logic [6:0]        Y_LIMIT  = 7'(HEIGHT);

  fb_state_t             state;
  logic [ADDR_W-1:0]     ptr;
  logic [COLOUR_W-1:0]   fill_colour;

  logic                  plot_on_screen;
  logic                  plot_accept;
  logic                  plot_drop;
  logic                  clear_write;
  logic                  rd_on_screen;
  logic                  rd_on_screen_q;

  logic                  we;
  logic [ADDR_W-1:0]     wr_addr;
  logic [COLOUR_W-1:0]   wr_data;
  logic [ADDR_W-1:0]     rd_addr;
  logic [COLOUR_W-1:0]   ram_rd_data;

  assign plot_on_screen = (vga_x < X_LIMIT) && (vga_y < Y_LIMIT);
  assign plot_accept    = vga_plot && (state == IDLE) && plot_on_screen;
  assign plot_drop      = vga_plot && !plot_accept;
  assign clear_write    = (state == CLEAR) && clear_start;
  assign rd_on_screen   = (rd_x < X_LIMIT) && (rd_y < Y_LIMIT);
  assign rd_addr        = rd_on_screen ? fb_addr(rd_x, rd_y, WIDTH) : '0;

  assign busy       = (state == CLEAR);
  assign clear_done = (state == DONE);
  assign rd_colour  = rd_on_screen_q ? ram_rd_data : '0;

  // Single write port: the clear sweep and accepted plots never coincide,
  // because plots are only accepted while idle.
  always_comb begin
    we      = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (clear_write) begin
      we      = 1'b1;
      wr_addr = ptr;
      wr_data = fill_colour;
    end else if (plot_accept) begin
      we      = 1'b1;
      wr_addr = fb_addr(vga_x, vga_y, WIDTH);
      wr_data = vga_colour;
    end
  end

  // Clear sequencer: latch the fill colour on entry, sweep in raster order,
  // abort to idle as soon as the request drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      fill_colour <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_start) begin
            state       <= CLEAR;
            ptr         <= '0;
            fill_colour <= clear_colour;
          end
        end
        CLEAR: begin
          if (!clear_start) begin
            state <= IDLE;
          end else if (ptr == LAST_PTR) begin
            state <= DONE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        DONE: begin
          if (!clear_start) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating tallies of accepted and rejected plot strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plot_count <= '0;
      drop_count <= '0;
    end else begin
      if (plot_accept && (plot_count != 16'hFFFF)) begin
        plot_count <= plot_count + 16'd1;
      end
      if (plot_drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  // Remember whether the read just issued was on-screen so off-screen reads return 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_on_screen_q <= 1'b0;
    end else begin
      rd_on_screen_q <= rd_on_screen;
    end
  end

  fb_ram #(
    .DATA_W (COLOUR_W),
    .DEPTH  (PIXELS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

endmodule

// File: tb/tb_framebuffer_sink.sv
// Randomised scoreboard bench for framebuffer_sink. A pixel-array reference
// model predicts every read; a separate monitor pops predictions when the
// registered read data appears. Status outputs are compared every cycle.
`timescale 1ns/1ps
module tb_framebuffer_sink;

  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  vga_x = '0;
  logic [6:0]  vga_y = '0;
  logic [2:0]  vga_colour = '0;
  logic        vga_plot = 1'b0;
  logic        clear_start = 1'b0;
  logic [2:0]  clear_colour = '0;
  logic        clear_done;
  logic        busy;
  logic [7:0]  rd_x = '0;
  logic [6:0]  rd_y = '0;
  logic [2:0]  rd_colour;
  logic [15:0] plot_count;
  logic [15:0] drop_count;

  framebuffer_sink dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_plot     (vga_plot),
    .clear_start  (clear_start),
    .clear_colour (clear_colour),
    .clear_done   (clear_done),
    .busy         (busy),
    .rd_x         (rd_x),
    .rd_y         (rd_y),
    .rd_colour    (rd_colour),
    .plot_count   (plot_count),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] colour;
    bit         known;
  } rd_exp_t;

  rd_exp_t    expq[$];
  logic [2:0] mem_m   [N];
  bit         known_m [N];
  bit         m_clearing;
  bit         m_done;
  int         m_cptr;
  logic [2:0] m_ccol;
  int         m_pc;
  int         m_dc;

  int vectors     = 0;
  int miscompares = 0;

  logic rd_req  = 1'b0;
  logic rd_pend = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // A read issued before edge N is presented on rd_colour after edge N.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pend <= 1'b0;
    else        rd_pend <= rd_req;
  end

  always @(negedge clk) begin : monitor
    rd_exp_t e;
    if (rd_pend) begin
      if (expq.size() == 0) begin
        checkOutput("rd_queue_underflow", 32'd1, 32'd0);
      end else begin
        e = expq.pop_front();
        if (e.known) checkOutput("rd_colour", 32'(rd_colour), 32'(e.colour));
      end
    end
  end

  // One clock of stimulus; the model predicts the state after the coming edge.
  task automatic applyStimulus(input bit plot, input int x, input int y, input logic [2:0] col,
                               input bit cs, input logic [2:0] cc,
                               input bit rd, input int rx, input int ry);
    rd_exp_t e;
    int a;
    bool_idle: begin end
    vga_plot     = plot;
    vga_x        = 8'(x);
    vga_y        = 7'(y);
    vga_colour   = col;
    clear_start  = cs;
    clear_colour = cc;
    rd_req       = rd;
    rd_x         = 8'(rx);
    rd_y         = 7'(ry);

    if (rd) begin
      if (rx < W && ry < H) begin
        a = ry * W + rx;
        e.colour = mem_m[a];
        e.known  = known_m[a];
      end else begin
        e.colour = 3'b000;
        e.known  = 1'b1;
      end
      expq.push_back(e);
    end

    if (plot) begin
      if (!m_clearing && !m_done && x < W && y < H) begin
        mem_m[y * W + x]   = col;
        known_m[y * W + x] = 1'b1;
        if (m_pc < 65535) m_pc++;
      end else begin
        if (m_dc < 65535) m_dc++;
      end
    end

    if (m_clearing) begin
      if (!cs) begin
        m_clearing = 1'b0;
      end else begin
        mem_m[m_cptr]   = m_ccol;
        known_m[m_cptr] = 1'b1;
        m_cptr++;
        if (m_cptr == N) begin
          m_clearing = 1'b0;
          m_done     = 1'b1;
        end
      end
    end else if (m_done) begin
      if (!cs) m_done = 1'b0;
    end else if (cs) begin
      m_clearing = 1'b1;
      m_cptr     = 0;
      m_ccol     = cc;
    end

    @(posedge clk);
    #1;
    checkOutput("busy", 32'(busy), 32'(m_clearing));
    checkOutput("clear_done", 32'(clear_done), 32'(m_done));
    checkOutput("plot_count", 32'(plot_count), 32'(m_pc));
    checkOutput("drop_count", 32'(drop_count), 32'(m_dc));
  endtask

  task automatic tick(input bit cs);
    applyStimulus(1'b0, 0, 0, 3'b000, cs, 3'b000, 1'b0, 0, 0);
  endtask

  task automatic plotPixel(input int x, input int y, input logic [2:0] col);
    applyStimulus(1'b1, x, y, col, 1'b0, 3'b000, 1'b0, 0, 0);
  endtask

  task automatic readPixel(input int x, input int y, input bit cs);
    applyStimulus(1'b0, 0, 0, 3'b000, cs, 3'b000, 1'b1, x, y);
  endtask

  // Full clear held until done; optionally fires stray plots while busy.
  task automatic doClear(input logic [2:0] col, input int stray_plots);
    int busy_cycles;
    busy_cycles = 0;
    applyStimulus(1'b0, 0, 0, 3'b000, 1'b1, col, 1'b0, 0, 0);
    if (busy) busy_cycles++;
    for (int i = 0; i < N + 100 && m_clearing; i++) begin
      applyStimulus(i < stray_plots, $urandom_range(W - 1), $urandom_range(H - 1),
                    3'($urandom), 1'b1, 3'b000, 1'b0, 0, 0);
      if (busy) busy_cycles++;
    end
    checkOutput("busy_cycles", 32'(busy_cycles), 32'(N));
  endtask

  task automatic applyReset();
    rst_n        = 1'b0;
    vga_plot     = 1'b0;
    clear_start  = 1'b0;
    rd_req       = 1'b0;
    m_clearing   = 1'b0;
    m_done       = 1'b0;
    m_pc         = 0;
    m_dc         = 0;
    expq.delete();
    #2;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_clear_done", 32'(clear_done), 32'd0);
    checkOutput("reset_plot_count", 32'(plot_count), 32'd0);
    checkOutput("reset_drop_count", 32'(drop_count), 32'd0);
    checkOutput("reset_rd_colour", 32'(rd_colour), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    for (int i = 0; i < N; i++) begin
      mem_m[i]   = 3'b000;
      known_m[i] = 1'b0;
    end
    m_cptr = 0;
    m_ccol = 3'b000;
    #1;
    applyReset();

    // Basic plot and read-back.
    plotPixel(10, 20, 3'b101);
    readPixel(10, 20, 1'b0);
    checkOutput("first_plot_count", 32'(plot_count), 32'd1);

    // Far corner accepted, one column past the edge dropped.
    plotPixel(159, 119, 3'b111);
    plotPixel(160, 5, 3'b010);
    readPixel(159, 119, 1'b0);
    readPixel(160, 5, 1'b0);
    checkOutput("edge_drop_count", 32'(drop_count), 32'd1);

    // Full clear with stray plots while busy; reads while holding in done.
    doClear(3'b011, 50);
    checkOutput("clear_drop_count", 32'(drop_count), 32'd51);
    readPixel(0, 0, 1'b1);
    readPixel(80, 60, 1'b1);
    readPixel(159, 119, 1'b1);
    applyStimulus(1'b1, 3, 3, 3'b100, 1'b1, 3'b000, 1'b0, 0, 0);
    tick(1'b0);
    tick(1'b0);

    // Prefill, then abort a clear after 100 written pixels.
    doClear(3'b110, 0);
    tick(1'b0);
    applyStimulus(1'b0, 0, 0, 3'b000, 1'b1, 3'b001, 1'b0, 0, 0);
    for (int i = 0; i < 100; i++) tick(1'b1);
    applyStimulus(1'b1, 20, 30, 3'b010, 1'b0, 3'b000, 1'b0, 0, 0);
    plotPixel(21, 30, 3'b101);
    for (int i = 0; i <= 100; i++) readPixel(i, 0, 1'b0);
    readPixel(21, 30, 1'b0);

    // Read-during-write on the same pixel returns the old value first.
    plotPixel(5, 5, 3'b000);
    applyStimulus(1'b1, 5, 5, 3'b100, 1'b0, 3'b000, 1'b1, 5, 5);
    readPixel(5, 5, 1'b0);

    // Random plots and reads, including off-screen coordinates on both ports.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(1), $urandom_range(170), $urandom_range(127), 3'($urandom),
                    1'b0, 3'b000, $urandom_range(1), $urandom_range(165), $urandom_range(125));
    end

    // Reset in the middle of a clear.
    applyStimulus(1'b0, 0, 0, 3'b000, 1'b1, 3'b010, 1'b0, 0, 0);
    for (int i = 0; i < 500; i++) tick(1'b1);
    applyReset();
    tick(1'b0);
    plotPixel(7, 7, 3'b011);
    readPixel(7, 7, 1'b0);
    readPixel(0, 0, 1'b0);
    tick(1'b0);
    tick(1'b0);
    checkOutput("queue_drained", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
